booth_mult_seq_n: RTL and testbench

// - Parametrised sequential radix-2 Booth multiplier; successor of the fixed 8-bit Booth datapath + FSM + counter.
// - Adds a signed/unsigned mode, a start/ready/done handshake, a held result and a sign-magnitude result port.
// - Sits between operand capture (switches/registers) and the BCD/7-segment display path.
// - Self-contained: internal FSM, iteration counter, add/sub and A:Q:q-1 shift register; no external alu/counter.

---
 rtl/booth_mult_seq_n_if.sv | 29 ++
 rtl/booth_mult_seq_n.sv | 166 ++++++++++++++++
 tb/tb_booth_mult_seq_n.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_n_if.sv
// Handshake/operand bundle for booth_mult_seq_n.
// master: the operand source (drives i_*), slave: the multiplier (drives o_*).
interface booth_mult_seq_n_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 2);

  logic               i_start;
  logic               i_signed;
  logic [WIDTH-1:0]   i_multiplicand;
  logic [WIDTH-1:0]   i_multiplier;
  logic               o_rdy;
  logic               o_busy;
  logic               o_done;
  logic [2*WIDTH-1:0] o_product;
  logic [2*WIDTH-1:0] o_mag;
  logic               o_sign;
  logic [CNT_W-1:0]   o_cnt;

  modport master (
    output i_start, i_signed, i_multiplicand, i_multiplier,
    input  o_rdy, o_busy, o_done, o_product, o_mag, o_sign, o_cnt
  );

  modport slave (
    input  i_start, i_signed, i_multiplicand, i_multiplier,
    output o_rdy, o_busy, o_done, o_product, o_mag, o_sign, o_cnt
  );
endinterface

// File: rtl/booth_mult_seq_n.sv
// Sequential radix-2 Booth multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Operands are extended to WIDTH+1 bits so one datapath serves signed and
// unsigned runs. One iteration per clock, E = WIDTH+1 iterations per run.
// Optional feature: define BOOTH_ZERO_SKIP_EN to finish immediately when
// either operand is zero.
module booth_mult_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  booth_mult_seq_n_if.slave bus
);
  localparam int E     = WIDTH + 1;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(E - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Sign- or zero-extend an operand to the internal width.
  function automatic logic [E-1:0] ext_op(input logic [WIDTH-1:0] v, input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  // Two's-complement magnitude when neg is set, pass-through otherwise.
  function automatic logic [PW-1:0] abs_val(input logic [PW-1:0] v, input logic neg);
    logic [PW-1:0] r;
    if (neg) begin
      r = ~v + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           r_state;
  logic [E-1:0]     r_a;
  logic [E-1:0]     r_q;
  logic             r_qm1;
  logic [E-1:0]     r_m;
  logic             r_signed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rdy;
  logic             r_busy;
  logic             r_done;
  logic [PW-1:0]    r_product;
  logic [PW-1:0]    r_mag;
  logic             r_sign;

  logic [E-1:0]     w_sum;
  logic [E-1:0]     w_a_nxt;
  logic [E-1:0]     w_q_nxt;
  logic [PW-1:0]    w_prod;
  logic             w_neg;

`ifdef BOOTH_ZERO_SKIP_EN
  logic             w_zero_op;
  assign w_zero_op = (bus.i_multiplicand == {WIDTH{1'b0}}) ||
                     (bus.i_multiplier == {WIDTH{1'b0}});
`endif

  // One Booth step: add/sub M per {Q[0],q-1}, then arithmetic shift of A:Q:q-1.
  // The product is taken from the post-shift value so the last step and the
  // result capture share one edge.
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
    w_a_nxt = {w_sum[E-1], w_sum[E-1:1]};
    w_q_nxt = {w_sum[0], r_q[E-1:1]};
    w_prod  = {w_a_nxt[WIDTH-2:0], w_q_nxt};
    w_neg   = r_signed & w_prod[PW-1];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= {E{1'b0}};
      r_q       <= {E{1'b0}};
      r_qm1     <= 1'b0;
      r_m       <= {E{1'b0}};
      r_signed  <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
      r_rdy     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= {PW{1'b0}};
      r_mag     <= {PW{1'b0}};
      r_sign    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_a      <= {E{1'b0}};
            r_q      <= ext_op(bus.i_multiplier, bus.i_signed);
            r_qm1    <= 1'b0;
            r_m      <= ext_op(bus.i_multiplicand, bus.i_signed);
            r_signed <= bus.i_signed;
            r_cnt    <= {CNT_W{1'b0}};
            r_rdy    <= 1'b0;
            r_busy   <= 1'b1;
`ifdef BOOTH_ZERO_SKIP_EN
            if (w_zero_op) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_product <= {PW{1'b0}};
              r_mag     <= {PW{1'b0}};
              r_sign    <= 1'b0;
            end else begin
              r_state   <= S_CALC;
            end
`else
            r_state  <= S_CALC;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_product <= w_prod;
            r_mag     <= abs_val(w_prod, w_neg);
            r_sign    <= w_neg;
          end else begin
            r_state   <= S_CALC;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_rdy     = r_rdy;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_product = r_product;
  assign bus.o_mag     = r_mag;
  assign bus.o_sign    = r_sign;
  assign bus.o_cnt     = r_cnt;
endmodule

// File: tb/tb_booth_mult_seq_n.sv
// Bench for booth_mult_seq_n: directed vector table at WIDTH=8, hand-written
// multi-cycle sequences, and random sweeps at WIDTH=4/8/16 against an
// integer-arithmetic reference. Inputs change on negedge, outputs sampled on negedge.
module tb_booth_mult_seq_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_mult_seq_n_if #(.WIDTH(4))  if4 ();
  booth_mult_seq_n_if #(.WIDTH(8))  if8 ();
  booth_mult_seq_n_if #(.WIDTH(16)) if16 ();

  booth_mult_seq_n #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  booth_mult_seq_n #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  booth_mult_seq_n #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    logic        rdy, busy, done, sign;
    logic [31:0] prod, mag;
    logic [7:0]  cnt;
  } obs_t;

  typedef struct {
    logic        sg;
    logic [7:0]  a, b;
    logic [15:0] p, m;
    logic        s;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic sg,
                       input logic [15:0] a, input logic [15:0] b);
    case (w)
      4: begin
        if4.i_start = st; if4.i_signed = sg;
        if4.i_multiplicand = a[3:0]; if4.i_multiplier = b[3:0];
      end
      16: begin
        if16.i_start = st; if16.i_signed = sg;
        if16.i_multiplicand = a; if16.i_multiplier = b;
      end
      default: begin
        if8.i_start = st; if8.i_signed = sg;
        if8.i_multiplicand = a[7:0]; if8.i_multiplier = b[7:0];
      end
    endcase
  endtask

  function automatic obs_t sample(input int w);
    obs_t o;
    case (w)
      4: begin
        o.rdy = if4.o_rdy; o.busy = if4.o_busy; o.done = if4.o_done; o.sign = if4.o_sign;
        o.prod = 32'(if4.o_product); o.mag = 32'(if4.o_mag); o.cnt = 8'(if4.o_cnt);
      end
      16: begin
        o.rdy = if16.o_rdy; o.busy = if16.o_busy; o.done = if16.o_done; o.sign = if16.o_sign;
        o.prod = 32'(if16.o_product); o.mag = 32'(if16.o_mag); o.cnt = 8'(if16.o_cnt);
      end
      default: begin
        o.rdy = if8.o_rdy; o.busy = if8.o_busy; o.done = if8.o_done; o.sign = if8.o_sign;
        o.prod = 32'(if8.o_product); o.mag = 32'(if8.o_mag); o.cnt = 8'(if8.o_cnt);
      end
    endcase
    return o;
  endfunction

  // Reference: interpret operands as integers, multiply, reduce to 2*w bits.
  function automatic void ref_mult(input int w, input logic sg, input logic [15:0] a,
                                   input logic [15:0] b, output logic [31:0] p,
                                   output logic [31:0] m, output logic s);
    longint av, bv, pr, mask2;
    av = longint'(a) & ((longint'(1) << w) - 1);
    bv = longint'(b) & ((longint'(1) << w) - 1);
    if (sg && av[w-1]) av = av - (longint'(1) << w);
    if (sg && bv[w-1]) bv = bv - (longint'(1) << w);
    pr    = av * bv;
    mask2 = (longint'(1) << (2 * w)) - 1;
    p = 32'(pr & mask2);
    m = 32'(((pr < 0) ? -pr : pr) & mask2);
    s = sg && (pr < 0);
  endfunction

  function automatic int exp_lat(input int w, input logic [15:0] a, input logic [15:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
    if (a == 16'd0 || b == 16'd0) return 1;
`endif
    return w + 2;
  endfunction

  function automatic int exp_cnt(input int w, input logic [15:0] a, input logic [15:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
    if (a == 16'd0 || b == 16'd0) return 0;
`endif
    return w + 1;
  endfunction

  // Start one run, scramble inputs after acceptance, wait (bounded) for o_done.
  // lat counts negedges from the one where i_start was raised.
  task automatic run_op(input int w, input logic sg, input logic [15:0] a,
                        input logic [15:0] b, output obs_t o, output int lat);
    obs_t pre;
    @(negedge clk);
    pre = sample(w);
    check("rdy_before_start", 64'(pre.rdy), 64'd1);
    check("done_is_pulse", 64'(pre.done), 64'd0);
    drive(w, 1'b1, sg, a, b);
    @(negedge clk);
    drive(w, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    lat = 1;
    o = sample(w);
    while (!o.done && lat < 60) begin
      @(negedge clk);
      lat++;
      o = sample(w);
    end
  endtask

  task automatic check_run(input string tag, input int w, input logic sg,
                           input logic [15:0] a, input logic [15:0] b);
    obs_t o;
    int lat;
    logic [31:0] ep, em;
    logic es;
    ref_mult(w, sg, a, b, ep, em, es);
    run_op(w, sg, a, b, o, lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat(w, a, b)));
    check({tag, "_product"}, 64'(o.prod), 64'(ep));
    check({tag, "_mag"}, 64'(o.mag), 64'(em));
    check({tag, "_sign"}, 64'(o.sign), 64'(es));
    check({tag, "_cnt"}, 64'(o.cnt), 64'(exp_cnt(w, a, b)));
    check({tag, "_busy_in_done"}, 64'({o.busy, o.rdy}), 64'b10);
  endtask

  vec_t vecs[10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t o;
    int lat, k, ndone;
    logic [31:0] cap;
    logic [15:0] ra, rb, mask;
    logic rs;

    vecs[0] = '{1'b1, 8'h07, 8'hFD, 16'hFFEB, 16'h0015, 1'b1};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, 16'h4000, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 16'hFE01, 1'b0};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 16'h0001, 1'b0};
    vecs[4] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 16'h3F80, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'hFB, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 8'h0C, 8'h00, 16'h0000, 16'h0000, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 8'h02, 16'h0100, 16'h0100, 1'b0};
    vecs[8] = '{1'b1, 8'h80, 8'h01, 16'hFF80, 16'h0080, 1'b1};
    vecs[9] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 16'h3F01, 1'b0};

    rst = 1'b1;
    drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    o = sample(8);
    check("reset_rdy", 64'(o.rdy), 64'd1);
    check("reset_busy_done", 64'({o.busy, o.done, o.sign}), 64'd0);
    check("reset_product", 64'(o.prod), 64'd0);
    check("reset_mag", 64'(o.mag), 64'd0);
    check("reset_cnt", 64'(o.cnt), 64'd0);

    // Directed table, back-to-back runs.
    for (int i = 0; i < 10; i++) begin
      run_op(8, vecs[i].sg, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, o, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat),
            64'(exp_lat(8, {8'h00, vecs[i].a}, {8'h00, vecs[i].b})));
      check($sformatf("vec%0d_product", i), 64'(o.prod), 64'(vecs[i].p));
      check($sformatf("vec%0d_mag", i), 64'(o.mag), 64'(vecs[i].m));
      check($sformatf("vec%0d_sign", i), 64'(o.sign), 64'(vecs[i].s));
    end

    // Starts while busy must be ignored.
    @(negedge clk);
    drive(8, 1'b1, 1'b1, 16'h0007, 16'h00FD);
    ndone = 0;
    cap = 32'd0;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      drive(8, (j == 3 || j == 6), 1'b0, 16'h0055, 16'h0033);
      o = sample(8);
      if (o.done) begin
        ndone++;
        cap = o.prod;
      end
    end
    check("busy_start_done_count", 64'(ndone), 64'd1);
    check("busy_start_product", 64'(cap), 64'h0000FFEB);

    // Reset in the middle of CALC.
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 16'h00AB, 16'h00CD);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 16'h0000, 16'h0000);
    k = 0;
    o = sample(8);
    while (o.cnt != 8'd4 && k < 20) begin
      @(negedge clk);
      k++;
      o = sample(8);
    end
    check("midrun_cnt4_reached", 64'(o.cnt), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o = sample(8);
    check("midrun_reset_rdy_busy_done", 64'({o.rdy, o.busy, o.done, o.sign}), 64'b1000);
    check("midrun_reset_product_mag", 64'({o.prod, o.mag}), 64'd0);
    check("midrun_reset_cnt", 64'(o.cnt), 64'd0);
    check_run("after_reset", 8, 1'b1, 16'h009C, 16'h0035);
    check("after_reset_known_product", 64'(if8.o_product), 64'h0000EB4C);

    // Random sweeps at three widths.
    foreach (vecs[i]) begin end
    for (int wi = 0; wi < 3; wi++) begin
      int w;
      w = (wi == 0) ? 4 : ((wi == 1) ? 8 : 16);
      mask = (w == 16) ? 16'hFFFF : ((w == 8) ? 16'h00FF : 16'h000F);
      for (int r = 0; r < 30; r++) begin
        ra = 16'($urandom) & mask;
        rb = 16'($urandom) & mask;
        if (r % 10 == 7) ra = 16'd0;
        rs = 1'($urandom);
        check_run($sformatf("rand_w%0d_%0d", w, r), w, rs, ra, rb);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
